// File: rtl/delay_echo_client.sv
// Initiator for one delay_master buffer: allocates once, then per sample reads the delayed tap,
// writes input plus feedback, and emits a dry/wet mix. Define DELAY_ECHO_CLIENT_TIMEOUT_EN for a reply watchdog.
module delay_echo_client #(
  parameter int unsigned data_width     = 16,
  parameter int unsigned addr_width     = 12,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic [data_width-1:0]   cfg_handle,
  input  logic [2*addr_width-1:0] cfg_size,
  input  logic [2*addr_width-1:0] cfg_delay,
  input  logic [data_width-1:0]   cfg_delay_inc,
  input  logic [7:0]              cfg_fb_gain,
  input  logic [7:0]              cfg_wet_gain,
  input  logic [data_width-1:0]   sample_in,
  input  logic                    sample_in_valid,
  output logic                    sample_in_ready,
  output logic [data_width-1:0]   sample_out,
  output logic                    sample_out_valid,
  output logic                    alloc_req,
  output logic [2*addr_width-1:0] alloc_size,
  output logic [2*addr_width-1:0] alloc_delay,
  output logic                    read_req,
  output logic [data_width-1:0]   read_handle,
  output logic                    write_req,
  output logic [data_width-1:0]   write_handle,
  output logic [data_width-1:0]   write_data,
  output logic [data_width-1:0]   write_inc,
  input  logic [data_width-1:0]   read_data,
  input  logic                    read_valid,
  input  logic                    write_ack,
  input  logic                    invalid_alloc,
  input  logic                    invalid_read,
  input  logic                    invalid_write,
  output logic                    allocated,
  output logic                    error,
  output logic                    overrun
);

  localparam int unsigned PW = data_width + 8;

  typedef enum logic [2:0] {
    StUnalloc, StAllocWait, StReady, StReadWait, StCalc, StWriteWait, StOutput, StAbort
  } state_e;

  state_e                  state_d, state_q;
  logic [data_width-1:0]   handle_d, handle_q, inc_d, inc_q, x_d, x_q, d_d, d_q;
  logic [2*addr_width-1:0] size_d, size_q, delay_d, delay_q;
  logic [7:0]              fb_gain_d, fb_gain_q, wet_gain_d, wet_gain_q;
  logic                    alloc_req_d, alloc_req_q, read_req_d, read_req_q;
  logic                    allocated_d, allocated_q, error_d, error_q, overrun_d, overrun_q;
  logic                    timeout_hit;

  logic signed [PW-1:0]    d_ext, fb_prod, wet_prod;
  logic [data_width-1:0]   fb_term, wet_term, wdata, out_acc;

  function automatic logic [data_width-1:0] sat_add(input logic [data_width-1:0] a,
                                                    input logic [data_width-1:0] b);
    logic [data_width:0] s;
    s = {a[data_width-1], a} + {b[data_width-1], b};
    if (s[data_width] != s[data_width-1]) begin
      sat_add = s[data_width] ? {1'b1, {(data_width-1){1'b0}}} : {1'b0, {(data_width-1){1'b1}}};
    end else begin
      sat_add = s[data_width-1:0];
    end
  endfunction

  // Gains are zero-extended so 0xFF means 255/256, never negative.
  always_comb begin
    d_ext    = {{8{d_q[data_width-1]}}, d_q};
    fb_prod  = d_ext * $signed({{data_width{1'b0}}, fb_gain_q});
    wet_prod = d_ext * $signed({{data_width{1'b0}}, wet_gain_q});
    fb_term  = fb_prod[PW-1:8];
    wet_term = wet_prod[PW-1:8];
    wdata    = sat_add(x_q, fb_term);
    out_acc  = sat_add(x_q, wet_term);
  end

`ifdef DELAY_ECHO_CLIENT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_cycles + 1);
  logic [CntW-1:0] wait_cnt_d, wait_cnt_q;
  logic            waiting;

  always_comb begin
    waiting     = state_q inside {StAllocWait, StReadWait, StWriteWait};
    wait_cnt_d  = waiting ? wait_cnt_q + CntW'(1) : '0;
    timeout_hit = waiting && (wait_cnt_q == CntW'(timeout_cycles));
  end

  always_ff @(posedge clk) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^timeout_cycles;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    handle_d    = handle_q;
    size_d      = size_q;
    delay_d     = delay_q;
    inc_d       = inc_q;
    fb_gain_d   = fb_gain_q;
    wet_gain_d  = wet_gain_q;
    x_d         = x_q;
    d_d         = d_q;
    alloc_req_d = 1'b0;
    read_req_d  = 1'b0;
    allocated_d = allocated_q;
    error_d     = error_q;
    overrun_d   = overrun_q | (sample_in_valid & (state_q != StReady));

    unique case (state_q)
      StUnalloc: begin
        if (cfg_start) begin
          handle_d    = cfg_handle;
          size_d      = cfg_size;
          delay_d     = cfg_delay;
          inc_d       = cfg_delay_inc;
          fb_gain_d   = cfg_fb_gain;
          wet_gain_d  = cfg_wet_gain;
          alloc_req_d = 1'b1;
          state_d     = StAllocWait;
        end
      end
      StAllocWait: begin
        // A reply in the request-pulse cycle belongs to nobody; judge on the second cycle.
        if (!alloc_req_q) begin
          if (invalid_alloc) begin
            error_d = 1'b1;
            state_d = StUnalloc;
          end else begin
            allocated_d = 1'b1;
            state_d     = StReady;
          end
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StUnalloc;
        end
      end
      StReady: begin
        if (sample_in_valid) begin
          x_d        = sample_in;
          inc_d      = cfg_delay_inc;
          fb_gain_d  = cfg_fb_gain;
          wet_gain_d = cfg_wet_gain;
          read_req_d = 1'b1;
          state_d    = StReadWait;
        end
      end
      StReadWait: begin
        if (!read_req_q && invalid_read) begin
          error_d = 1'b1;
          state_d = StAbort;
        end else if (!read_req_q && read_valid) begin
          d_d     = read_data;
          state_d = StCalc;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StAbort;
        end
      end
      StCalc: state_d = StWriteWait;
      StWriteWait: begin
        if (invalid_write || timeout_hit) begin
          error_d = 1'b1;
          state_d = StAbort;
        end else if (write_ack) begin
          state_d = StOutput;
        end
      end
      StOutput, StAbort: state_d = StReady;
      default: state_d = StUnalloc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StUnalloc;
      handle_q    <= '0;
      size_q      <= '0;
      delay_q     <= '0;
      inc_q       <= '0;
      fb_gain_q   <= '0;
      wet_gain_q  <= '0;
      x_q         <= '0;
      d_q         <= '0;
      alloc_req_q <= 1'b0;
      read_req_q  <= 1'b0;
      allocated_q <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      handle_q    <= handle_d;
      size_q      <= size_d;
      delay_q     <= delay_d;
      inc_q       <= inc_d;
      fb_gain_q   <= fb_gain_d;
      wet_gain_q  <= wet_gain_d;
      x_q         <= x_d;
      d_q         <= d_d;
      alloc_req_q <= alloc_req_d;
      read_req_q  <= read_req_d;
      allocated_q <= allocated_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
    end
  end

  // The write request is the CALC cycle itself; its data comes from held registers.
  always_comb begin
    sample_in_ready  = (state_q == StReady);
    sample_out_valid = (state_q == StOutput) || (state_q == StAbort);
    sample_out       = (state_q == StOutput) ? out_acc :
                       (state_q == StAbort)  ? x_q     : '0;
    alloc_req        = alloc_req_q;
    alloc_size       = size_q;
    alloc_delay      = delay_q;
    read_req         = read_req_q;
    read_handle      = handle_q;
    write_req        = (state_q == StCalc);
    write_handle     = handle_q;
    write_data       = wdata;
    write_inc        = inc_q;
    allocated        = allocated_q;
    error            = error_q;
    overrun          = overrun_q;
  end

endmodule

// File: tb/tb_delay_echo_client.sv
// Self-checking bench for delay_echo_client: table vectors, hand sequences, and randomized
// samples checked against an arithmetic reference model with a scripted delay_master responder.
module tb_delay_echo_client;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_handle = '0;
  logic [23:0] cfg_size = '0;
  logic [23:0] cfg_delay = '0;
  logic [15:0] cfg_delay_inc = '0;
  logic [7:0]  cfg_fb_gain = '0;
  logic [7:0]  cfg_wet_gain = '0;
  logic [15:0] sample_in = '0;
  logic        sample_in_valid = 1'b0;
  logic        sample_in_ready;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        alloc_req;
  logic [23:0] alloc_size;
  logic [23:0] alloc_delay;
  logic        read_req;
  logic [15:0] read_handle;
  logic        write_req;
  logic [15:0] write_handle;
  logic [15:0] write_data;
  logic [15:0] write_inc;
  logic [15:0] read_data = '0;
  logic        read_valid = 1'b0;
  logic        write_ack = 1'b0;
  logic        invalid_alloc = 1'b0;
  logic        invalid_read = 1'b0;
  logic        invalid_write = 1'b0;
  logic        allocated;
  logic        error;
  logic        overrun;

  delay_echo_client #(
    .data_width    (16),
    .addr_width    (12),
    .timeout_cycles(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_handle      (cfg_handle),
    .cfg_size        (cfg_size),
    .cfg_delay       (cfg_delay),
    .cfg_delay_inc   (cfg_delay_inc),
    .cfg_fb_gain     (cfg_fb_gain),
    .cfg_wet_gain    (cfg_wet_gain),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_in_ready (sample_in_ready),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .alloc_req       (alloc_req),
    .alloc_size      (alloc_size),
    .alloc_delay     (alloc_delay),
    .read_req        (read_req),
    .read_handle     (read_handle),
    .write_req       (write_req),
    .write_handle    (write_handle),
    .write_data      (write_data),
    .write_inc       (write_inc),
    .read_data       (read_data),
    .read_valid      (read_valid),
    .write_ack       (write_ack),
    .invalid_alloc   (invalid_alloc),
    .invalid_read    (invalid_read),
    .invalid_write   (invalid_write),
    .allocated       (allocated),
    .error           (error),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_id = -1;
  bit exp_err = 1'b0;
  bit exp_ovr = 1'b0;

  typedef struct {
    int x; int rd; int fbg; int wg; int rlat; int wlat;
    bit rinv; bit winv; bit junk; bit dup;
    int exp_wd; int exp_out;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (case %0d): got %0d, expected %0d", name, cur_id, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Floor of d*g/256.
  function automatic int scale(input int d, input int g);
    return (d * g) >>> 8;
  endfunction

  task automatic do_alloc(input bit bad);
    cfg_handle = 16'd3;
    cfg_size   = 24'd256;
    cfg_delay  = 24'h004000;
    cfg_start  = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("alloc_req_pulse", alloc_req, 1);
    check("alloc_size", alloc_size, 256);
    check("alloc_delay", alloc_delay, 'h4000);
    invalid_alloc = !bad;  // same-cycle reply must be ignored
    tick();
    check("alloc_req_width", alloc_req, 0);
    invalid_alloc = bad;
    tick();
    invalid_alloc = 1'b0;
    check("allocated", allocated, !bad);
    check("alloc_error", error, bad);
    check("ready_after_alloc", sample_in_ready, !bad);
  endtask

  task automatic run_sample(input int x, input int rd, input int fbg, input int wg,
                            input int rlat, input int wlat, input bit rinv, input bit winv,
                            input bit junk, input bit dup, input int exp_wd, input int exp_out,
                            input int exp_lat, input int exp_nwr);
    int rp, wp, nval, lat, nwr;
    logic [15:0] outv, wd;
    rp = -1; wp = -1; nval = 0; lat = -1; nwr = 0; outv = '0; wd = '0;
    cfg_fb_gain  = fbg[7:0];
    cfg_wet_gain = wg[7:0];
    check("ready_before", sample_in_ready, 1);
    sample_in       = x[15:0];
    sample_in_valid = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      sample_in_valid = 1'b0;
      read_valid = 1'b0; invalid_read = 1'b0; write_ack = 1'b0; invalid_write = 1'b0;
      read_data = '0;
      if (read_req) begin
        rp = k;
        check("read_handle", read_handle, 3);
      end
      if (write_req) begin
        wp = k;
        nwr++;
        wd = write_data;
        check("write_handle", write_handle, 3);
        check("write_inc", write_inc, cfg_delay_inc);
      end
      if (sample_out_valid) begin
        nval++;
        if (lat < 0) begin
          lat  = k;
          outv = sample_out;
        end
      end
      if (junk && read_req) invalid_read = 1'b1;
      if (rp > 0 && k == rp + rlat) begin
        if (rinv) invalid_read = 1'b1;
        else begin
          read_valid = 1'b1;
          read_data  = rd[15:0];
        end
      end
      if (dup && wp > 0 && k == wp + 1) begin
        sample_in       = 16'h7777;
        sample_in_valid = 1'b1;
      end
      if (wp > 0 && k == wp + wlat) begin
        if (winv) invalid_write = 1'b1;
        else      write_ack = 1'b1;
      end
      if (lat > 0 && k >= lat + 3) break;
    end
    read_valid = 1'b0; invalid_read = 1'b0; write_ack = 1'b0; invalid_write = 1'b0;
    sample_in_valid = 1'b0;
    check("out_valid_count", nval, 1);
    check("latency", lat, exp_lat);
    check("sample_out", $signed(outv), exp_out);
    check("write_count", nwr, exp_nwr);
    if (exp_nwr > 0) check("write_data", $signed(wd), exp_wd);
    check("error_flag", error, exp_err);
    check("overrun_flag", overrun, exp_ovr);
    check("ready_after", sample_in_ready, 1);
  endtask

  vec_t tbl[9];

  initial begin
    int npulse;
    tbl[0] = '{1000, 2000, 128, 128, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2000, 2000};
    tbl[1] = '{30000, 30000, 128, 128, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32767, 32767};
    tbl[2] = '{-30000, -30000, 128, 128, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0, -32768, -32768};
    tbl[3] = '{500, 1000, 0, 64, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 500, 750};
    tbl[4] = '{-100, 256, 255, 0, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 155, -100};
    tbl[5] = '{0, -1, 128, 128, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1};
    tbl[6] = '{200, -400, 128, 255, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 0, -199};
    tbl[7] = '{1234, 55, 128, 128, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1234};
    tbl[8] = '{-77, 100, 128, 128, 1, 3, 1'b0, 1'b1, 1'b0, 1'b0, -27, -77};

    tick();
    tick();
    check("reset_outputs_zero",
          |{sample_in_ready, sample_out, sample_out_valid, alloc_req, alloc_size, alloc_delay,
            read_req, read_handle, write_req, write_handle, write_data, write_inc,
            allocated, error, overrun}, 0);
    reset = 1'b1;
    tick();

    cur_id = 100;
    do_alloc(1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    cur_id = 101;
    do_alloc(1'b0);
    cfg_start = 1'b1;
    cfg_handle = 16'd9;
    tick();
    cfg_start = 1'b0;
    check("cfg_start_ignored", alloc_req, 0);
    check("still_ready", sample_in_ready, 1);

    cfg_delay_inc = 16'hFFFE;
    foreach (tbl[i]) begin
      cur_id = i;
      exp_err = exp_err | tbl[i].rinv | tbl[i].winv;
      exp_ovr = exp_ovr | tbl[i].dup;
      run_sample(tbl[i].x, tbl[i].rd, tbl[i].fbg, tbl[i].wg, tbl[i].rlat, tbl[i].wlat,
                 tbl[i].rinv, tbl[i].winv, tbl[i].junk, tbl[i].dup, tbl[i].exp_wd,
                 tbl[i].exp_out,
                 tbl[i].rinv ? tbl[i].rlat + 2 : tbl[i].rlat + tbl[i].wlat + 3,
                 tbl[i].rinv ? 0 : 1);
    end

    // Reset while a read is outstanding.
    cur_id = 200;
    sample_in = 16'd42;
    sample_in_valid = 1'b1;
    tick();
    sample_in_valid = 1'b0;
    check("midreset_read_req_seen", read_req, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_outputs_zero",
          |{sample_in_ready, sample_out, sample_out_valid, alloc_req, alloc_size, alloc_delay,
            read_req, read_handle, write_req, write_handle, write_data, write_inc,
            allocated, error, overrun}, 0);
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      read_valid = 1'b1;
      write_ack  = 1'b1;
      tick();
      npulse += int'(read_req) + int'(write_req) + int'(alloc_req) + int'(sample_out_valid);
    end
    read_valid = 1'b0;
    write_ack  = 1'b0;
    check("midreset_no_pulses", npulse, 0);
    check("midreset_unalloc", sample_in_ready, 0);
    exp_err = 1'b0;
    exp_ovr = 1'b0;
    cur_id = 201;
    do_alloc(1'b0);

    for (int i = 0; i < 40; i++) begin
      int x, rd, fbg, wg, rlat, wlat;
      bit rinv, winv;
      cur_id = 300 + i;
      x    = int'($urandom_range(0, 65535)) - 32768;
      rd   = int'($urandom_range(0, 65535)) - 32768;
      fbg  = int'($urandom_range(0, 255));
      wg   = int'($urandom_range(0, 255));
      rlat = int'($urandom_range(1, 4));
      wlat = int'($urandom_range(1, 4));
      rinv = ($urandom_range(0, 7) == 0);
      winv = !rinv && ($urandom_range(0, 7) == 0);
      cfg_delay_inc = 16'($urandom_range(0, 65535));
      exp_err = exp_err | rinv | winv;
      run_sample(x, rd, fbg, wg, rlat, wlat, rinv, winv, 1'b0, 1'b0,
                 sat16(x + scale(rd, fbg)),
                 (rinv || winv) ? x : sat16(x + scale(rd, wg)),
                 rinv ? rlat + 2 : rlat + wlat + 3,
                 rinv ? 0 : 1);
    end

`ifdef DELAY_ECHO_CLIENT_TIMEOUT_EN
    // No read reply: watchdog fires nine cycles after read_req and passes the dry sample.
    cur_id = 400;
    exp_err = 1'b1;
    run_sample(-4321, 0, 128, 128, 1000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, -4321, 10, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
